// File: rtl/huff_decode_ctrl_if.sv
// ---------------------------------------------------------------------------
// huff_decode_ctrl_if
//   Bundles the two byte-wide buses the Huffman decode sequencer drives:
//   the shared input FIFO read side and the code-dictionary write port.
//
//   Handshake semantics (both buses):
//     FIFO  : first-word-fall-through. fifo_data is valid whenever empty=0.
//             The consumer pops by raising r_en in a cycle where empty=0;
//             the head byte is consumed at the next rising clock edge.
//             r_en is never raised while empty=1.
//     DICT  : write-only strobe, no backpressure. dict_waddr and dict_wdata
//             are valid in every cycle where dict_we=1 and are written at
//             the next rising clock edge.
//
//   Modports
//     master : sequencer side (drives r_en and the dictionary write port)
//     slave  : FIFO / dictionary side
// ---------------------------------------------------------------------------
interface huff_decode_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              empty;
    logic [7:0]        fifo_data;
    logic              r_en;
    logic              dict_we;
    logic [ADDR_W-1:0] dict_waddr;
    logic [7:0]        dict_wdata;

    modport master (
        input  empty,
        input  fifo_data,
        output r_en,
        output dict_we,
        output dict_waddr,
        output dict_wdata
    );

    modport slave (
        output empty,
        output fifo_data,
        input  r_en,
        input  dict_we,
        input  dict_waddr,
        input  dict_wdata
    );
endinterface

// File: rtl/huff_decode_ctrl.sv
// ---------------------------------------------------------------------------
// huff_decode_ctrl
//   Top-level sequencer of the Huffman decode datapath. Parses the 3-byte
//   stream header (entry count N, 16-bit character total) from the shared
//   input FIFO, copies N*DICT_BYTES dictionary bytes into the dictionary,
//   then hands the FIFO to the decode path and counts emitted characters
//   until the declared total is reached. Completion and errors are sticky
//   until the next start.
//
//   Optional feature (macro DEC_WDT_EN): watchdog that aborts DECODE with
//   err_code 3 when no character is emitted for WDT_CYCLES non-stalled
//   cycles. Without the macro there is no watchdog logic at all.
//
//   Ports
//     clk, n_rst  : clock, asynchronous active-low reset
//     start       : one-cycle pulse, begins a stream (ignored while busy)
//     bus         : FIFO read side + dictionary write port (master modport)
//     dec_r_en    : FIFO read request from the decode path
//     chsent      : one pulse per decoded character written out
//     dict_err    : decode path found no dictionary match
//     out_full    : output FIFO full, stalls the decode path
//     dict_ready  : dictionary loaded, decode path may run
//     dec_en      : decode path enable
//     busy        : sequencer active (not IDLE/DONE/ERR)
//     done, err   : sticky completion / error flags
//     err_code    : 0 none, 1 bad header, 2 dict_err, 3 watchdog
//     char_cnt    : characters emitted in the current stream (saturating)
//     dbg_state   : current FSM state encoding
// ---------------------------------------------------------------------------
module huff_decode_ctrl #(
    parameter int DICT_BYTES  = 2,
    parameter int MAX_ENTRIES = 256,
    parameter int ADDR_W      = 9,
    parameter int WDT_CYCLES  = 1024
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    huff_decode_ctrl_if.master  bus,
    input  logic                dec_r_en,
    input  logic                chsent,
    input  logic                dict_err,
    input  logic                out_full,
    output logic                dict_ready,
    output logic                dec_en,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [15:0]         char_cnt,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_HDR_N      = 3'd1,
        S_HDR_LEN_HI = 3'd2,
        S_HDR_LEN_LO = 3'd3,
        S_LOAD       = 3'd4,
        S_DECODE     = 3'd5,
        S_DONE       = 3'd6,
        S_ERR        = 3'd7
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_HDR  = 2'd1;
    localparam logic [1:0] ERR_DICT = 2'd2;
`ifdef DEC_WDT_EN
    localparam logic [1:0] ERR_WDT  = 2'd3;
`endif

    localparam logic [31:0] DICT_BYTES_U  = 32'(DICT_BYTES);
    localparam logic [31:0] MAX_ENTRIES_U = 32'(MAX_ENTRIES);

    // Parameter sanity: the address register must reach the last entry.
    if ((MAX_ENTRIES * DICT_BYTES - 1) >= (1 << ADDR_W) || WDT_CYCLES < 1)
    begin : g_param_check
        $error("huff_decode_ctrl: inconsistent ADDR_W/MAX_ENTRIES/WDT_CYCLES");
    end

    state_t            state;
    logic [15:0]       total;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] last_addr;   // N*DICT_BYTES-1, latched from the header

    logic              empty;
    logic [7:0]        fifo_data;
    logic              r_en_c;
    logic              dict_we_c;
    logic              dec_en_c;
    logic [8:0]        n_val;
    logic [31:0]       n_bytes;
    logic [ADDR_W-1:0] last_calc;
    logic [15:0]       cnt_next;
    logic [15:0]       total_lo_calc;

`ifdef DEC_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(WDT_CYCLES);
    logic [WDT_W-1:0] wdt_cnt;
    logic [WDT_W-1:0] wdt_next;
    assign wdt_next = wdt_cnt + 1'b1;
`endif

    assign empty     = bus.empty;
    assign fifo_data = bus.fifo_data;

    // Header byte 0 encodes 256 entries.
    assign n_val         = (fifo_data == 8'd0) ? 9'd256 : {1'b0, fifo_data};
    assign n_bytes       = 32'(n_val) * DICT_BYTES_U;
    assign last_calc     = ADDR_W'(n_bytes - 32'd1);
    assign cnt_next      = (char_cnt == 16'hFFFF) ? char_cnt : char_cnt + 16'd1;
    assign total_lo_calc = {total[15:8], fifo_data};

    // FIFO pop and dictionary strobe are combinational so that a popped
    // byte is written to the dictionary in the same cycle.
    always_comb begin
        r_en_c    = 1'b0;
        dict_we_c = 1'b0;
        dec_en_c  = 1'b0;
        case (state)
            S_HDR_N, S_HDR_LEN_HI, S_HDR_LEN_LO: begin
                r_en_c = !empty;
            end
            S_LOAD: begin
                r_en_c    = !empty;
                dict_we_c = !empty;
            end
            S_DECODE: begin
                dec_en_c = !out_full;
                r_en_c   = dec_r_en & !empty & !out_full;
            end
            default: begin
                r_en_c = 1'b0;
            end
        endcase
    end

    assign bus.r_en       = r_en_c;
    assign bus.dict_we    = dict_we_c;
    assign bus.dict_waddr = waddr;
    assign bus.dict_wdata = dict_we_c ? fifo_data : 8'h00;
    assign dec_en         = dec_en_c;

    // busy is a pure decode of the state register.
    assign busy      = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign dbg_state = state;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            total      <= 16'd0;
            waddr      <= '0;
            last_addr  <= '0;
            dict_ready <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            char_cnt   <= 16'd0;
`ifdef DEC_WDT_EN
            wdt_cnt    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_HDR_N;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        err_code   <= ERR_NONE;
                        char_cnt   <= 16'd0;
                        waddr      <= '0;
                        dict_ready <= 1'b0;
                    end
                end

                S_HDR_N: begin
                    if (!empty) begin
                        if (32'(n_val) > MAX_ENTRIES_U) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            err_code <= ERR_HDR;
                        end else begin
                            last_addr <= last_calc;
                            state     <= S_HDR_LEN_HI;
                        end
                    end
                end

                S_HDR_LEN_HI: begin
                    if (!empty) begin
                        total[15:8] <= fifo_data;
                        state       <= S_HDR_LEN_LO;
                    end
                end

                S_HDR_LEN_LO: begin
                    if (!empty) begin
                        total[7:0] <= fifo_data;
                        // An empty stream finishes without loading the dictionary.
                        if (total_lo_calc == 16'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    if (!empty) begin
                        waddr <= waddr + 1'b1;
                        if (waddr == last_addr) begin
                            state      <= S_DECODE;
                            dict_ready <= 1'b1;
`ifdef DEC_WDT_EN
                            wdt_cnt    <= '0;
`endif
                        end
                    end
                end

                S_DECODE: begin
                    if (chsent) begin
                        char_cnt <= cnt_next;
                    end
                    // dict_err takes priority over a completing chsent.
                    if (dict_err) begin
                        state      <= S_ERR;
                        err        <= 1'b1;
                        err_code   <= ERR_DICT;
                        dict_ready <= 1'b0;
                    end else if (chsent) begin
`ifdef DEC_WDT_EN
                        wdt_cnt <= '0;
`endif
                        if (cnt_next == total) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            dict_ready <= 1'b0;
                        end
                    end
`ifdef DEC_WDT_EN
                    else if (!out_full) begin
                        // Stalled cycles (out_full) do not age the watchdog.
                        if (wdt_next == WDT_LIMIT) begin
                            state      <= S_ERR;
                            err        <= 1'b1;
                            err_code   <= ERR_WDT;
                            dict_ready <= 1'b0;
                        end else begin
                            wdt_cnt <= wdt_next;
                        end
                    end
`endif
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
